booth_mult_ctrl: RTL and testbench



---
 rtl/booth_mult_ctrl_pkg.sv | 35 +++
 rtl/carry_select_adder_32.sv | 50 +++++
 rtl/booth_mult_ctrl.sv | 164 ++++++++++++++++
 tb/tb_booth_mult_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared constants for the sequential Booth multiplier:
//               datapath width, iteration count, FSM state encoding and
//               Booth step opcodes, plus the radix-2 Booth decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int WIDTH = 32;
    localparam int STEPS = 32;
    localparam int CNT_W = $clog2(STEPS);

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Booth step opcodes
    localparam logic [1:0] OP_SKIP = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_m1}.
    function automatic logic [1:0] booth_op(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b10:   return OP_SUB;
            2'b01:   return OP_ADD;
            default: return OP_SKIP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/carry_select_adder_32.sv
`default_nettype none
// ============================================================================
// Module      : carry_select_adder_32
// Description : 32-bit combinational carry-select adder built from eight
//               4-bit blocks. Each block precomputes its sum for carry-in 0
//               and 1; the incoming block carry selects between them.
//               Also exposes the carry into and out of bit 31 so callers can
//               derive signed overflow.
// Ports       : i_a, i_b   - 32-bit addends
//               i_c_in     - carry into bit 0
//               o_sum      - 32-bit sum
//               o_c_in_31  - carry into bit 31
//               o_c_out_31 - carry out of bit 31
// Revision    : 1.0 - initial release
// ============================================================================
module carry_select_adder_32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_c_in,
    output logic [31:0] o_sum,
    output logic        o_c_in_31,
    output logic        o_c_out_31
);

    localparam int c_BLK    = 4;
    localparam int c_NBLK   = 32 / c_BLK;

    logic [c_NBLK:0] w_carry;

    assign w_carry[0] = i_c_in;

    for (genvar g = 0; g < c_NBLK; g++) begin : g_blk
        logic [c_BLK:0] w_s0;
        logic [c_BLK:0] w_s1;

        assign w_s0 = {1'b0, i_a[g*c_BLK +: c_BLK]} + {1'b0, i_b[g*c_BLK +: c_BLK]};
        assign w_s1 = {1'b0, i_a[g*c_BLK +: c_BLK]} + {1'b0, i_b[g*c_BLK +: c_BLK]}
                      + {{c_BLK{1'b0}}, 1'b1};

        assign o_sum[g*c_BLK +: c_BLK] = w_carry[g] ? w_s1[c_BLK-1:0] : w_s0[c_BLK-1:0];
        assign w_carry[g+1]            = w_carry[g] ? w_s1[c_BLK]     : w_s0[c_BLK];
    end

    // The sum bit is a ^ b ^ carry_in, so the carry into the MSB falls out
    // of the MSB sum without exposing block internals.
    assign o_c_in_31  = i_a[31] ^ i_b[31] ^ o_sum[31];
    assign o_c_out_31 = w_carry[c_NBLK];

endmodule
`default_nettype wire

// File: rtl/booth_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_ctrl
// Description : Sequential 32x32 signed radix-2 Booth multiplier. One
//               add/sub/skip step per cycle through a shared carry-select
//               adder, 32 steps per multiply, start/ready handshake.
// Ports       : clock      - system clock, rising edge
//               reset      - synchronous active-high reset
//               start      - multiply request, honoured in IDLE or DONE
//               operand_a  - multiplicand M (two's complement)
//               operand_b  - multiplier Q (two's complement)
//               busy       - high while iterating
//               result_rdy - one-cycle pulse in DONE
//               result     - low 32 bits of product, valid with result_rdy
//               exception  - signed overflow, valid with result_rdy
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_ctrl #(
    parameter int WIDTH = mult_pkg::WIDTH,  // only 32 supported (adder width)
    parameter int STEPS = mult_pkg::STEPS   // must equal WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             result_rdy,
    output logic [WIDTH-1:0] result,
    output logic             exception
);

    import mult_pkg::CNT_W;
    import mult_pkg::IDLE;
    import mult_pkg::BUSY;
    import mult_pkg::DONE;
    import mult_pkg::OP_SKIP;
    import mult_pkg::OP_ADD;
    import mult_pkg::OP_SUB;
    import mult_pkg::booth_op;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic             r_q_m1;
    logic [WIDTH-1:0] r_m;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_result_rdy;
    logic [WIDTH-1:0] r_result;
    logic             r_exception;

    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_c_in_31;
    logic             w_c_out_31;
    logic             w_ts;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_q_next;

    // Booth decode: subtract uses A + ~M + 1; skip feeds zero so sum == A.
    always_comb begin
        w_op      = booth_op(r_q[0], r_q_m1);
        w_add_b   = '0;
        w_add_cin = 1'b0;
        case (w_op)
            OP_SUB: begin
                w_add_b   = ~r_m;
                w_add_cin = 1'b1;
            end
            OP_ADD: begin
                w_add_b   = r_m;
            end
            default: ;
        endcase
    end

    carry_select_adder_32 u_adder (
        .i_a        (r_a),
        .i_b        (w_add_b),
        .i_c_in     (w_add_cin),
        .o_sum      (w_sum),
        .o_c_in_31  (w_c_in_31),
        .o_c_out_31 (w_c_out_31)
    );

    // The arithmetic shift needs the true sign of A+/-M; when the 32-bit add
    // overflows (e.g. subtracting M = 0x80000000) sum[31] is wrong, and the
    // MSB carry mismatch flips it back.
    always_comb begin
        if (w_op == OP_SKIP) begin
            w_ts = r_a[WIDTH-1];
        end else begin
            w_ts = w_sum[WIDTH-1] ^ (w_c_in_31 ^ w_c_out_31);
        end
        w_a_next = {w_ts, w_sum[WIDTH-1:1]};
        w_q_next = {w_sum[0], r_q[WIDTH-1:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_q          <= '0;
            r_q_m1       <= 1'b0;
            r_m          <= '0;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_result_rdy <= 1'b0;
            r_result     <= '0;
            r_exception  <= 1'b0;
        end else begin
            // Result outputs are a single-cycle pulse; only the final step
            // overrides these defaults.
            r_result_rdy <= 1'b0;
            r_result     <= '0;
            r_exception  <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_m     <= operand_a;
                        r_q     <= operand_b;
                        r_a     <= '0;
                        r_q_m1  <= 1'b0;
                        r_count <= '0;
                        r_state <= BUSY;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                BUSY: begin
                    r_a     <= w_a_next;
                    r_q     <= w_q_next;
                    r_q_m1  <= r_q[0];
                    r_count <= r_count + 1'b1;
                    if (r_count == CNT_W'(STEPS - 1)) begin
                        r_state      <= DONE;
                        r_busy       <= 1'b0;
                        r_result_rdy <= 1'b1;
                        r_result     <= w_q_next;
                        // Overflow when the high word is not a pure sign
                        // extension of the low word.
                        r_exception  <= (w_a_next != {WIDTH{w_q_next[WIDTH-1]}});
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign result_rdy = r_result_rdy;
    assign result     = r_result;
    assign exception  = r_exception;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mult_ctrl
// Description : Self-checking bench for booth_mult_ctrl. Expected products
//               come from a 64-bit signed reference multiply, queued when a
//               multiply is launched and popped when result_rdy pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult_ctrl;

    localparam int c_MAXW = 60;

    typedef struct packed {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        result_rdy;
    logic [31:0] result;
    logic        exception;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    booth_mult_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .result_rdy (result_rdy),
        .result     (result),
        .exception  (exception)
    );

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        longint p;
        exp_t   e;
        p     = longint'($signed(a)) * longint'($signed(b));
        e.res = p[31:0];
        e.exc = (p[63:32] != {32{p[31]}});
        return e;
    endfunction

    // Drive a request at a falling edge and queue its expected result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        sb.push_back(model(a, b));
    endtask

    // Step falling edges until result_rdy. n counts rising edges from the
    // accepting edge (inclusive). mode 0: drop start; 1: hold start and
    // scramble operands; 2: random start pulses and scrambled operands.
    task automatic wait_rdy(input int mode, output int n, output int nbusy);
        n     = 0;
        nbusy = 0;
        forever begin
            @(negedge clock);
            n++;
            nbusy += int'(busy);
            if (result_rdy || n >= c_MAXW) break;
            case (mode)
                0: start = 1'b0;
                1: begin
                    operand_a = $urandom;
                    operand_b = $urandom;
                end
                default: begin
                    start     = (n < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
                    operand_a = $urandom;
                    operand_b = $urandom;
                end
            endcase
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        start     = 1'b0;
        operand_a = 32'h1234_5678;
        operand_b = 32'h9abc_def0;
        repeat (3) @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (result_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got=%b want=0", result_rdy); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h want=0", result); end
        n_checks++; if (exception !== 1'b0) begin n_fail++; $display("FAIL reset_exc got=%b want=0", exception); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (busy !== 1'b0 || result_rdy !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_start got busy=%b rdy=%b want 0/0", busy, result_rdy);
        end
    endtask

    task automatic test_products;
        logic [31:0] av[$];
        logic [31:0] bv[$];
        int          n;
        int          nb;
        exp_t        e;
        av = '{32'd3, 32'hFFFF_FFF9, 32'd5,        32'h8000_0000, 32'hFFFF_FFFF,
               32'h0001_0000, 32'h7FFF_FFFF, 32'hDEAD_BEEF};
        bv = '{32'd4, 32'd5,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000,
               32'h0001_0000, 32'd1,         32'h0000_1F2F};
        for (int i = 0; i < av.size(); i++) begin
            issue(av[i], bv[i]);
            wait_rdy(0, n, nb);
            e = sb.pop_front();
            n_checks++; if (n != 33) begin n_fail++; $display("FAIL prod%0d_latency got=%0d want=33", i, n); end
            n_checks++; if (nb != 32) begin n_fail++; $display("FAIL prod%0d_busy_cycles got=%0d want=32", i, nb); end
            n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL prod%0d_result got=%h want=%h", i, result, e.res); end
            n_checks++; if (exception !== e.exc) begin n_fail++; $display("FAIL prod%0d_exc got=%b want=%b", i, exception, e.exc); end
            @(negedge clock);
            n_checks++; if (result_rdy !== 1'b0 || result !== 32'h0) begin
                n_fail++; $display("FAIL prod%0d_pulse got rdy=%b result=%h want 0/0", i, result_rdy, result);
            end
        end
        // Spot-check a few reference values independent of the model.
        n_checks++; if (model(32'hFFFF_FFF9, 32'd5) !== {32'hFFFF_FFDD, 1'b0}) begin
            n_fail++; $display("FAIL model_neg got=%h want=ffffffdd/0", model(32'hFFFF_FFF9, 32'd5));
        end
    endtask

    task automatic test_busy_ignore;
        int   n;
        int   nb;
        exp_t e;
        issue(32'd2, 32'd3);
        @(negedge clock);
        wait_rdy(2, n, nb);
        n++;
        e = sb.pop_front();
        n_checks++; if (n != 33) begin n_fail++; $display("FAIL ignore_latency got=%0d want=33", n); end
        n_checks++; if (result !== e.res || e.res !== 32'd6) begin n_fail++; $display("FAIL ignore_result got=%h want=6", result); end
        start = 1'b0;
        @(negedge clock);
        n_checks++; if (busy !== 1'b0 || result_rdy !== 1'b0) begin
            n_fail++; $display("FAIL ignore_idle got busy=%b rdy=%b want 0/0", busy, result_rdy);
        end
    endtask

    task automatic test_back_to_back;
        int   n;
        int   nb;
        exp_t e;
        issue(32'd2, 32'd3);
        wait_rdy(1, n, nb);
        e = sb.pop_front();
        n_checks++; if (n != 33) begin n_fail++; $display("FAIL b2b_first_latency got=%0d want=33", n); end
        n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL b2b_first_result got=%h want=%h", result, e.res); end
        issue(32'd6, 32'd7);
        wait_rdy(1, n, nb);
        e = sb.pop_front();
        n_checks++; if (n != 33) begin n_fail++; $display("FAIL b2b_spacing got=%0d want=33", n); end
        n_checks++; if (nb != 32) begin n_fail++; $display("FAIL b2b_busy_cycles got=%0d want=32", nb); end
        n_checks++; if (result !== e.res || e.res !== 32'd42) begin n_fail++; $display("FAIL b2b_second_result got=%h want=0000002a", result); end
        start = 1'b0;
        @(negedge clock);
        n_checks++; if (busy !== 1'b0 || result_rdy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle got busy=%b rdy=%b want 0/0", busy, result_rdy);
        end
    endtask

    task automatic test_reset_abort;
        int   n;
        int   nb;
        int   seen;
        exp_t e;
        operand_a = 32'd5;
        operand_b = 32'd5;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (busy !== 1'b0 || result_rdy !== 1'b0 || result !== 32'h0 || exception !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs got busy=%b rdy=%b result=%h exc=%b want all 0",
                     busy, result_rdy, result, exception);
        end
        reset = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(negedge clock);
            seen += int'(result_rdy) + int'(busy);
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_rdy got=%0d want=0", seen); end
        issue(32'd9, 32'd9);
        wait_rdy(0, n, nb);
        e = sb.pop_front();
        n_checks++; if (n != 33) begin n_fail++; $display("FAIL after_abort_latency got=%0d want=33", n); end
        n_checks++; if (result !== e.res || e.res !== 32'd81) begin n_fail++; $display("FAIL after_abort_result got=%h want=00000051", result); end
        n_checks++; if (exception !== 1'b0) begin n_fail++; $display("FAIL after_abort_exc got=%b want=0", exception); end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_products();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got=%0d want=0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
